// File: rtl/hog_pkg.sv
// hog_pkg: shared constants, bin index type and drain FSM state for the HOG cell accumulator
package hog_pkg;
  localparam int NBINS = 9;
  localparam int ACC_W = 20;
  localparam int MOD_W = 12;
  typedef logic [3:0] bin_t;
  typedef enum logic {IDLE, DRAIN} drain_state_t;
endpackage

// File: rtl/hog_bin_bank.sv
// hog_bin_bank: one bank of NBINS accumulators with dual-vote add, clear and read mux
// HOG_ACC_SATURATE_EN selects saturating instead of wrapping accumulation
module hog_bin_bank import hog_pkg::*; #(
  parameter int ACC_W = hog_pkg::ACC_W,
  parameter int NBINS = hog_pkg::NBINS
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             add_en,
  input  bin_t             bottom_bin,
  input  logic [MOD_W-1:0] top_modulus,
  input  logic [MOD_W-1:0] bottom_modulus,
  input  bin_t             rd_bin,
  output logic [ACC_W-1:0] rd_sum
);
  logic [ACC_W-1:0] acc [NBINS];
  logic [ACC_W-1:0] nxt [NBINS];
`ifdef HOG_ACC_SATURATE_EN
  logic [ACC_W:0] sum [NBINS];
`endif
  bin_t top_bin;
  assign top_bin = bottom_bin == bin_t'(NBINS - 1) ? '0 : bottom_bin + 1'b1;
  assign rd_sum = acc[rd_bin];
  always_comb
    for (int i = 0; i < NBINS; i++) begin
`ifdef HOG_ACC_SATURATE_EN
      sum[i] = {1'b0, acc[i]} + (ACC_W+1)'(bottom_bin == bin_t'(i) ? bottom_modulus : '0)
             + (ACC_W+1)'(top_bin == bin_t'(i) ? top_modulus : '0);
      nxt[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
`else
      nxt[i] = acc[i] + ACC_W'(bottom_bin == bin_t'(i) ? bottom_modulus : '0)
             + ACC_W'(top_bin == bin_t'(i) ? top_modulus : '0);
`endif
    end
  // clear wins over add: a discarded cell also drops its final pixel
  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < NBINS; i++) acc[i] <= '0;
    else if (clr)
      for (int i = 0; i < NBINS; i++) acc[i] <= '0;
    else if (add_en && bottom_bin < bin_t'(NBINS))
      for (int i = 0; i < NBINS; i++) acc[i] <= nxt[i];
endmodule

// File: rtl/hog_cell_accumulator.sv
// hog_cell_accumulator: ping-pong HOG cell histogram, one bank accumulating while the other drains
// HOG_ACC_SATURATE_EN selects saturating bin accumulators (default wraps)
module hog_cell_accumulator import hog_pkg::*; #(
  parameter int ACC_W = hog_pkg::ACC_W,
  parameter int NBINS = hog_pkg::NBINS
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             de,
  input  bin_t             bottom_bin,
  input  logic [MOD_W-1:0] top_modulus,
  input  logic [MOD_W-1:0] bottom_modulus,
  input  logic             cell_last,
  output logic             out_valid,
  input  logic             out_ready,
  output bin_t             out_bin,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_last,
  output logic             overflow,
  output logic [7:0]       drop_count
);
  drain_state_t state;
  logic sel, free, swap, drop;
  logic [ACC_W-1:0] sum0, sum1;
  assign out_valid = state == DRAIN;
  assign out_last = out_valid && out_bin == bin_t'(NBINS - 1);
  assign free = !out_valid || (out_ready && out_last);
  assign swap = de && cell_last && free;
  assign drop = de && cell_last && !free;
  assign out_sum = sel ? sum0 : sum1;
  // sel names the accumulating bank; the other one drains and is wiped when it is handed back
  hog_bin_bank #(.ACC_W(ACC_W), .NBINS(NBINS)) u_bank0 (
    .pclk, .reset_n, .clr(sel ? swap : drop), .add_en(de && !sel),
    .bottom_bin, .top_modulus, .bottom_modulus, .rd_bin(out_bin), .rd_sum(sum0)
  );
  hog_bin_bank #(.ACC_W(ACC_W), .NBINS(NBINS)) u_bank1 (
    .pclk, .reset_n, .clr(sel ? drop : swap), .add_en(de && sel),
    .bottom_bin, .top_modulus, .bottom_modulus, .rd_bin(out_bin), .rd_sum(sum1)
  );
  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sel <= 1'b0;
      out_bin <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      sel <= sel ^ swap;
      overflow <= overflow | drop;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if (swap) begin
        state <= DRAIN;
        out_bin <= '0;
      end else if (out_valid && out_ready) begin
        state <= out_last ? IDLE : DRAIN;
        out_bin <= out_last ? '0 : out_bin + 1'b1;
      end
    end
endmodule
